save_state_sequencer: RTL and testbench



---
 rtl/save_state_pkg.sv | 37 +++
 rtl/save_state_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_save_state_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/save_state_pkg.sv
// Purpose: shared state encoding, header layout and address packing for the save-state sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package save_state_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PAUSE,
    DELAY,
    HDR_REQ,
    HDR_WAIT,
    CORE_RD,
    DATA_REQ,
    DATA_WAIT,
    CORE_WR,
    FINISH,
    ABORT
  } ss_state_e;

  localparam logic [31:0] SS_MAGIC_DEFAULT = 32'h4E45_5353;

  // Header word layout: signature in the upper half, word count in the lower half.
  localparam int MAGIC_HI = 63;
  localparam int MAGIC_LO = 32;
  localparam int COUNT_HI = 31;
  localparam int COUNT_LO = 0;

  localparam int IDX_W     = 20;
  localparam int SS_ADDR_W = 26;
  localparam int TMO_W     = 24;

  // The controller addresses 32-bit halves, so a 64-bit word index lands at bit 1.
  function automatic logic [SS_ADDR_W-1:0] ss_addr_pack(input logic [IDX_W-1:0] word_idx);
    return {5'b0, word_idx, 1'b0};
  endfunction

endpackage

// File: rtl/save_state_sequencer.sv
// Purpose: pauses the core and streams its state words to/from the save-state controller behind a header word.
// Latency: first ss_req START_DELAY+1 cycles after core_paused is seen; one transaction in flight at a time.
// Backpressure: waits for ss_ack per request (bounded by ACK_TIMEOUT), waits on core_paused before starting.
// Ports: ss_save/ss_load triggers; ss_* word bus to the controller; core_* pause handshake and state port;
//        ss_busy spans the operation, ss_done pulses on success, ss_error is sticky until the next start.
module save_state_sequencer
  import save_state_pkg::*;
#(
  parameter int unsigned WORDS           = 256,
  parameter logic [31:0] MAGIC           = SS_MAGIC_DEFAULT,
  parameter int unsigned START_DELAY     = 8,
  parameter int unsigned CORE_RD_LATENCY = 2,
  parameter int unsigned ACK_TIMEOUT     = 1_000_000
) (
  input  logic                 clk_ppu_21_47,
  input  logic                 reset_n,
  input  logic                 ss_save,
  input  logic                 ss_load,
  output logic                 ss_req,
  output logic                 ss_rnw,
  output logic [SS_ADDR_W-1:0] ss_addr,
  output logic [63:0]          ss_dout,
  output logic [7:0]           ss_be,
  input  logic [63:0]          ss_din,
  input  logic                 ss_ack,
  output logic                 ss_busy,
  output logic                 core_pause_req,
  input  logic                 core_paused,
  output logic [IDX_W-1:0]     core_addr,
  output logic                 core_rd,
  input  logic [63:0]          core_rdata,
  output logic                 core_wr,
  output logic [63:0]          core_wdata,
  output logic                 ss_done,
  output logic                 ss_error
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [7:0]       DLY_INIT = 8'(START_DELAY);
  localparam logic [3:0]       LAT_INIT = 4'(CORE_RD_LATENCY);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = '1;
  localparam logic [63:0]      HDR_WORD = {MAGIC, 32'(WORDS)};

  ss_state_e state_q, state_d;
  logic load_mode_q, load_mode_d;
  logic save_prev_q, load_prev_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0] dly_q, dly_d;
  logic [3:0] lat_q, lat_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic ss_req_q, ss_req_d, ss_rnw_q, ss_rnw_d;
  logic [SS_ADDR_W-1:0] ss_addr_q, ss_addr_d;
  logic [63:0] ss_dout_q, ss_dout_d, core_wdata_q, core_wdata_d;
  logic ss_busy_q, ss_busy_d, core_pause_req_q, core_pause_req_d;
  logic [IDX_W-1:0] core_addr_q, core_addr_d;
  logic core_rd_q, core_rd_d, core_wr_q, core_wr_d;
  logic ss_done_q, ss_done_d, ss_error_q, ss_error_d;

  logic save_rise, load_rise, hdr_ok, go_abort, go_finish;

  assign save_rise = ss_save & ~save_prev_q;
  assign load_rise = ss_load & ~load_prev_q;
  assign hdr_ok    = (ss_din[MAGIC_HI:MAGIC_LO] == MAGIC) && (ss_din[COUNT_HI:COUNT_LO] == 32'(WORDS));

  always_comb begin
    state_d          = state_q;
    load_mode_d      = load_mode_q;
    idx_d            = idx_q;
    dly_d            = dly_q;
    lat_d            = lat_q;
    tmo_d            = tmo_q;
    ss_req_d         = 1'b0;
    ss_rnw_d         = ss_rnw_q;
    ss_addr_d        = ss_addr_q;
    ss_dout_d        = ss_dout_q;
    ss_busy_d        = ss_busy_q;
    core_pause_req_d = core_pause_req_q;
    core_addr_d      = core_addr_q;
    core_rd_d        = 1'b0;
    core_wr_d        = 1'b0;
    core_wdata_d     = core_wdata_q;
    ss_done_d        = 1'b0;
    ss_error_d       = ss_error_q;
    go_abort         = 1'b0;
    go_finish        = 1'b0;

    // Pulse outputs are set on the transition into their state so that the
    // registered strobe lines up with the cycle the FSM sits in that state.
    unique case (state_q)
      IDLE: begin
        if (load_rise || save_rise) begin
          load_mode_d      = load_rise;
          idx_d            = '0;
          ss_error_d       = 1'b0;
          ss_busy_d        = 1'b1;
          core_pause_req_d = 1'b1;
          state_d          = PAUSE;
        end
      end
      PAUSE: begin
        if (core_paused) begin
          dly_d   = DLY_INIT;
          state_d = DELAY;
        end
      end
      DELAY: begin
        // Leaving at 1 rather than 0 absorbs the PAUSE->DELAY cycle.
        if (dly_q <= 8'd1) begin
          ss_req_d  = 1'b1;
          ss_rnw_d  = load_mode_q;
          ss_addr_d = ss_addr_pack('0);
          if (!load_mode_q) ss_dout_d = HDR_WORD;
          state_d   = HDR_REQ;
        end else begin
          dly_d = dly_q - 8'd1;
        end
      end
      HDR_REQ, DATA_REQ: begin
        tmo_d   = '0;
        state_d = (state_q == HDR_REQ) ? HDR_WAIT : DATA_WAIT;
      end
      HDR_WAIT: begin
        if (ss_ack) begin
          if (!load_mode_q) begin
            core_rd_d   = 1'b1;
            core_addr_d = idx_q;
            lat_d       = LAT_INIT;
            state_d     = CORE_RD;
          end else if (hdr_ok) begin
            ss_req_d  = 1'b1;
            ss_rnw_d  = 1'b1;
            ss_addr_d = ss_addr_pack(idx_q + IDX_W'(1));
            state_d   = DATA_REQ;
          end else begin
            go_abort = 1'b1;
          end
        end else if (tmo_q >= TMO_LAST) begin
          go_abort = 1'b1;
        end else if (tmo_q != TMO_MAX) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      CORE_RD: begin
        if (lat_q == 4'd0) begin
          ss_dout_d = core_rdata;
          ss_req_d  = 1'b1;
          ss_rnw_d  = 1'b0;
          ss_addr_d = ss_addr_pack(idx_q + IDX_W'(1));
          state_d   = DATA_REQ;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      DATA_WAIT: begin
        if (ss_ack) begin
          if (!load_mode_q) begin
            if (idx_q == LAST_IDX) begin
              go_finish = 1'b1;
            end else begin
              idx_d       = idx_q + IDX_W'(1);
              core_rd_d   = 1'b1;
              core_addr_d = idx_q + IDX_W'(1);
              lat_d       = LAT_INIT;
              state_d     = CORE_RD;
            end
          end else begin
            core_wdata_d = ss_din;
            core_wr_d    = 1'b1;
            core_addr_d  = idx_q;
            // Busy tracks the bus: it drops one cycle after the last ack even
            // though the final core write and release are still to come.
            if (idx_q == LAST_IDX) ss_busy_d = 1'b0;
            state_d      = CORE_WR;
          end
        end else if (tmo_q >= TMO_LAST) begin
          go_abort = 1'b1;
        end else if (tmo_q != TMO_MAX) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      CORE_WR: begin
        if (idx_q == LAST_IDX) begin
          go_finish = 1'b1;
        end else begin
          idx_d     = idx_q + IDX_W'(1);
          ss_req_d  = 1'b1;
          ss_rnw_d  = 1'b1;
          ss_addr_d = ss_addr_pack(idx_q + IDX_W'(2));
          state_d   = DATA_REQ;
        end
      end
      FINISH, ABORT: state_d = IDLE;
      default:       state_d = IDLE;
    endcase

    if (go_abort) begin
      ss_error_d       = 1'b1;
      ss_busy_d        = 1'b0;
      core_pause_req_d = 1'b0;
      state_d          = ABORT;
    end
    if (go_finish) begin
      ss_done_d        = 1'b1;
      ss_busy_d        = 1'b0;
      core_pause_req_d = 1'b0;
      state_d          = FINISH;
    end
  end

  always_ff @(posedge clk_ppu_21_47 or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      load_mode_q      <= 1'b0;
      save_prev_q      <= 1'b0;
      load_prev_q      <= 1'b0;
      idx_q            <= '0;
      dly_q            <= '0;
      lat_q            <= '0;
      tmo_q            <= '0;
      ss_req_q         <= 1'b0;
      ss_rnw_q         <= 1'b0;
      ss_addr_q        <= '0;
      ss_dout_q        <= '0;
      ss_busy_q        <= 1'b0;
      core_pause_req_q <= 1'b0;
      core_addr_q      <= '0;
      core_rd_q        <= 1'b0;
      core_wr_q        <= 1'b0;
      core_wdata_q     <= '0;
      ss_done_q        <= 1'b0;
      ss_error_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      load_mode_q      <= load_mode_d;
      save_prev_q      <= ss_save;
      load_prev_q      <= ss_load;
      idx_q            <= idx_d;
      dly_q            <= dly_d;
      lat_q            <= lat_d;
      tmo_q            <= tmo_d;
      ss_req_q         <= ss_req_d;
      ss_rnw_q         <= ss_rnw_d;
      ss_addr_q        <= ss_addr_d;
      ss_dout_q        <= ss_dout_d;
      ss_busy_q        <= ss_busy_d;
      core_pause_req_q <= core_pause_req_d;
      core_addr_q      <= core_addr_d;
      core_rd_q        <= core_rd_d;
      core_wr_q        <= core_wr_d;
      core_wdata_q     <= core_wdata_d;
      ss_done_q        <= ss_done_d;
      ss_error_q       <= ss_error_d;
    end
  end

  assign ss_req         = ss_req_q;
  assign ss_rnw         = ss_rnw_q;
  assign ss_addr        = ss_addr_q;
  assign ss_dout        = ss_dout_q;
  assign ss_be          = 8'hFF;
  assign ss_busy        = ss_busy_q;
  assign core_pause_req = core_pause_req_q;
  assign core_addr      = core_addr_q;
  assign core_rd        = core_rd_q;
  assign core_wr        = core_wr_q;
  assign core_wdata     = core_wdata_q;
  assign ss_done        = ss_done_q;
  assign ss_error       = ss_error_q;

endmodule

// File: tb/tb_save_state_sequencer.sv
module tb_save_state_sequencer;

  localparam int WORDS       = 4;
  localparam int START_DELAY = 8;
  localparam int RD_LAT      = 2;
  localparam int ACK_TO      = 16;
  localparam logic [31:0] MAGIC = 32'h4E45_5353;

  logic clk_ppu_21_47, reset_n, ss_save, ss_load;
  logic ss_req, ss_rnw, ss_ack, ss_busy, core_pause_req, core_paused;
  logic core_rd, core_wr, ss_done, ss_error;
  logic [25:0] ss_addr;
  logic [63:0] ss_dout, ss_din, core_rdata, core_wdata;
  logic [7:0]  ss_be;
  logic [19:0] core_addr;

  save_state_sequencer #(
    .WORDS(WORDS), .MAGIC(MAGIC), .START_DELAY(START_DELAY),
    .CORE_RD_LATENCY(RD_LAT), .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .clk_ppu_21_47(clk_ppu_21_47), .reset_n(reset_n), .ss_save(ss_save), .ss_load(ss_load),
    .ss_req(ss_req), .ss_rnw(ss_rnw), .ss_addr(ss_addr), .ss_dout(ss_dout), .ss_be(ss_be),
    .ss_din(ss_din), .ss_ack(ss_ack), .ss_busy(ss_busy), .core_pause_req(core_pause_req),
    .core_paused(core_paused), .core_addr(core_addr), .core_rd(core_rd), .core_rdata(core_rdata),
    .core_wr(core_wr), .core_wdata(core_wdata), .ss_done(ss_done), .ss_error(ss_error)
  );

  initial clk_ppu_21_47 = 1'b0;
  always #5 clk_ppu_21_47 = ~clk_ppu_21_47;

  int cyc = 0;
  always @(posedge clk_ppu_21_47) cyc <= cyc + 1;

  typedef struct packed { logic rnw; logic [25:0] addr; logic [63:0] dat; } ss_txn_t;
  typedef struct packed { logic [19:0] addr; logic [63:0] dat; } cw_t;
  typedef struct packed { logic done; logic err; logic chk_ack; logic chk_tmo; } end_t;

  ss_txn_t exp_ss[$];
  cw_t     exp_cw[$];
  end_t    exp_end[$];

  logic [63:0] core_mem [WORDS];
  logic [63:0] ctl_mem  [WORDS+1];

  int checks = 0, failures = 0;
  int ack_min = 1, ack_max = 8, drop_req_n = 0, req_in_op = 0;
  int last_ack_cyc = -10, last_req_cyc = 0, paused_cyc = 0;
  bit first_req_pending = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got event 0x%0h, expected none (cycle %0d)", name, act, cyc);
  endtask

  // Controller responder: acks each request after a random delay.
  initial begin : responder
    int pend;
    bit awaiting;
    logic [63:0] rdat;
    int widx;
    pend = 0; awaiting = 0; rdat = '0;
    ss_ack = 1'b0; ss_din = '0;
    forever begin
      @(negedge clk_ppu_21_47);
      ss_ack = 1'b0;
      ss_din = {$urandom, $urandom};
      if (!reset_n) begin
        pend = 0; awaiting = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            ss_ack = 1'b1; ss_din = rdat; last_ack_cyc = cyc; awaiting = 0;
          end
        end
        if (ss_req === 1'b1) begin
          req_in_op++;
          check("req_protocol", 64'(!awaiting && (cyc > last_ack_cyc)), 64'd1);
          last_req_cyc = cyc;
          if (req_in_op != drop_req_n) begin
            widx = int'(ss_addr[20:1]);
            rdat = (widx <= WORDS) ? ctl_mem[widx] : 64'h0;
            pend = $urandom_range(ack_max, ack_min);
            awaiting = 1;
          end
        end
      end
    end
  end

  // Core pause handshake with a random response delay.
  initial begin : pauser
    int wait_n;
    wait_n = 0; core_paused = 1'b0;
    forever begin
      @(negedge clk_ppu_21_47);
      if (!reset_n || core_pause_req !== 1'b1) begin
        core_paused = 1'b0; wait_n = $urandom_range(3, 0);
      end else if (!core_paused) begin
        if (wait_n == 0) begin core_paused = 1'b1; paused_cyc = cyc; end
        else wait_n--;
      end
    end
  end

  // Core state port: data valid exactly RD_LAT cycles after the read strobe, garbage otherwise.
  initial begin : core_model
    int cnt;
    int a;
    cnt = 0; a = 0; core_rdata = '0;
    forever begin
      @(negedge clk_ppu_21_47);
      core_rdata = {$urandom, $urandom};
      if (!reset_n) cnt = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) core_rdata = (a < WORDS) ? core_mem[a] : 64'h0;
      end
      if (core_rd === 1'b1) begin cnt = RD_LAT; a = int'(core_addr); end
    end
  end

  // Monitor: pops expected events whenever the DUT presents one.
  initial begin : monitor
    logic prev_busy, prev_pause, held_vld;
    logic [63:0] held;
    ss_txn_t t; cw_t w; end_t e;
    prev_busy = 0; prev_pause = 0; held_vld = 0; held = '0;
    forever begin
      @(negedge clk_ppu_21_47);
      #1;
      if (!reset_n) begin
        prev_busy = 0; prev_pause = 0; held_vld = 0;
      end else begin
        if (ss_ack && held_vld) begin
          check("ss_dout_held", ss_dout, held); held_vld = 0;
        end
        if (ss_req) begin
          if (exp_ss.size() == 0) fail_event("ss_req_unexpected", 64'(ss_addr));
          else begin
            t = exp_ss.pop_front();
            check("ss_rnw", 64'(ss_rnw), 64'(t.rnw));
            check("ss_addr", 64'(ss_addr), 64'(t.addr));
            if (!t.rnw) begin check("ss_dout", ss_dout, t.dat); held = ss_dout; held_vld = 1; end
          end
          if (first_req_pending) begin
            check("start_delay", 64'(cyc - paused_cyc), 64'(START_DELAY + 1));
            first_req_pending = 0;
          end
        end
        if (core_wr) begin
          if (exp_cw.size() == 0) fail_event("core_wr_unexpected", 64'(core_addr));
          else begin
            w = exp_cw.pop_front();
            check("core_wr_addr", 64'(core_addr), 64'(w.addr));
            check("core_wdata", core_wdata, w.dat);
          end
        end
        if (ss_busy && !prev_busy) check("error_cleared_at_start", 64'(ss_error), 64'd0);
        if (!ss_busy && prev_busy) begin
          if (exp_end.size() == 0) fail_event("busy_fall_unexpected", 64'(cyc));
          else if (exp_end[0].chk_ack) check("busy_fall_after_ack", 64'(cyc - last_ack_cyc), 64'd1);
        end
        if (!core_pause_req && prev_pause) begin
          if (exp_end.size() == 0) fail_event("op_end_unexpected", 64'(cyc));
          else begin
            e = exp_end.pop_front();
            check("ss_done", 64'(ss_done), 64'(e.done));
            check("ss_error", 64'(ss_error), 64'(e.err));
            check("busy_low_at_end", 64'(ss_busy), 64'd0);
            if (e.chk_tmo) check("timeout_abort_cycle", 64'(cyc - last_req_cyc), 64'(ACK_TO + 1));
          end
        end else if (ss_done) fail_event("ss_done_spurious", 64'(cyc));
        prev_busy = ss_busy; prev_pause = core_pause_req;
      end
    end
  end

  // Reference model: expected traffic derived from the bus/header rules.
  task automatic plan_save();
    exp_ss.push_back('{1'b0, 26'd0, {MAGIC, 32'(WORDS)}});
    for (int i = 0; i < WORDS; i++) exp_ss.push_back('{1'b0, 26'((i + 1) * 2), core_mem[i]});
    exp_end.push_back('{1'b1, 1'b0, 1'b1, 1'b0});
  endtask

  task automatic plan_load();
    bit ok;
    ok = (ctl_mem[0] == {MAGIC, 32'(WORDS)});
    exp_ss.push_back('{1'b1, 26'd0, 64'd0});
    if (ok) begin
      for (int i = 0; i < WORDS; i++) begin
        exp_ss.push_back('{1'b1, 26'((i + 1) * 2), 64'd0});
        exp_cw.push_back('{20'(i), ctl_mem[i + 1]});
      end
      exp_end.push_back('{1'b1, 1'b0, 1'b1, 1'b0});
    end else begin
      exp_end.push_back('{1'b0, 1'b1, 1'b1, 1'b0});
    end
  endtask

  task automatic start_op(input bit do_load, input bit do_save);
    @(negedge clk_ppu_21_47);
    req_in_op = 0; first_req_pending = 1;
    ss_load = do_load; ss_save = do_save;
    @(negedge clk_ppu_21_47);
    ss_load = 1'b0; ss_save = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (exp_end.size() != 0 && n < budget) begin @(negedge clk_ppu_21_47); n++; end
    if (exp_end.size() != 0) begin
      fail_event("op_end_timeout", 64'(exp_end.size()));
      exp_end.delete();
    end
    repeat (3) @(negedge clk_ppu_21_47);
    check("ss_queue_drained", 64'(exp_ss.size()), 64'd0);
    check("core_wr_queue_drained", 64'(exp_cw.size()), 64'd0);
    exp_ss.delete(); exp_cw.delete();
  endtask

  task automatic set_valid_load_image();
    ctl_mem[0] = {MAGIC, 32'(WORDS)};
    for (int i = 1; i <= WORDS; i++) ctl_mem[i] = {$urandom, $urandom};
  endtask

  initial begin : watchdog
    #500000;
    failures++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    bit do_load;
    int r;
    reset_n = 1'b0; ss_save = 1'b0; ss_load = 1'b0;
    for (int i = 0; i < WORDS; i++) core_mem[i] = 64'hA0 + 64'(i);
    for (int i = 0; i <= WORDS; i++) ctl_mem[i] = '0;
    repeat (3) @(negedge clk_ppu_21_47);
    check("rst_ss_req", 64'(ss_req), 64'd0);
    check("rst_ss_busy", 64'(ss_busy), 64'd0);
    check("rst_pause_req", 64'(core_pause_req), 64'd0);
    check("rst_ss_be", 64'(ss_be), 64'hFF);
    check("rst_ss_addr", 64'(ss_addr), 64'd0);
    check("rst_strobes", 64'({core_rd, core_wr, ss_done, ss_error}), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_ppu_21_47);

    // Directed save with fixed ack latency of 3.
    ack_min = 3; ack_max = 3;
    plan_save(); start_op(0, 1); wait_end(400);

    // Directed load of 11,22,33,44.
    ctl_mem[0] = {MAGIC, 32'(WORDS)};
    ctl_mem[1] = 64'h11; ctl_mem[2] = 64'h22; ctl_mem[3] = 64'h33; ctl_mem[4] = 64'h44;
    plan_load(); start_op(1, 0); wait_end(400);
    check("load_ok_error", 64'(ss_error), 64'd0);

    // Load with a zero signature is rejected and the error is sticky.
    ctl_mem[0] = {32'h0, 32'(WORDS)};
    plan_load(); start_op(1, 0); wait_end(400);
    check("bad_hdr_error_sticky", 64'(ss_error), 64'd1);

    // Second request never acknowledged: timeout abort.
    drop_req_n = 2;
    exp_ss.push_back('{1'b0, 26'd0, {MAGIC, 32'(WORDS)}});
    exp_ss.push_back('{1'b0, 26'd2, core_mem[0]});
    exp_end.push_back('{1'b0, 1'b1, 1'b0, 1'b1});
    start_op(0, 1); wait_end(400);
    check("timeout_error_sticky", 64'(ss_error), 64'd1);
    drop_req_n = 0;

    // Simultaneous edges run as load; a mid-operation save trigger is ignored.
    set_valid_load_image();
    plan_load(); start_op(1, 1);
    repeat (15) @(negedge clk_ppu_21_47);
    ss_save = 1'b1;
    @(negedge clk_ppu_21_47);
    ss_save = 1'b0;
    wait_end(400);
    repeat (20) @(negedge clk_ppu_21_47);
    check("no_second_op", 64'(ss_busy), 64'd0);

    // Reset while waiting for a data ack.
    ack_min = 6; ack_max = 6;
    plan_save(); start_op(0, 1);
    n = 0;
    while (req_in_op < 3 && n < 400) begin @(negedge clk_ppu_21_47); #2; n++; end
    check("reached_data_wait", 64'(req_in_op >= 3), 64'd1);
    @(negedge clk_ppu_21_47);
    #2 reset_n = 1'b0;
    #1;
    check("arst_ss_busy", 64'(ss_busy), 64'd0);
    check("arst_pause_req", 64'(core_pause_req), 64'd0);
    check("arst_ss_req", 64'(ss_req), 64'd0);
    check("arst_done_error", 64'({ss_done, ss_error}), 64'd0);
    exp_ss.delete(); exp_cw.delete(); exp_end.delete();
    repeat (2) @(negedge clk_ppu_21_47);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_ppu_21_47);
    ack_min = 3; ack_max = 3;
    plan_save(); start_op(0, 1); wait_end(400);

    // Randomized operations with random contents, ack latency and header faults.
    ack_min = 1; ack_max = 8;
    for (int op = 0; op < 10; op++) begin
      do_load = 1'($urandom_range(1, 0));
      if (do_load) begin
        set_valid_load_image();
        r = $urandom_range(3, 0);
        if (r == 0) ctl_mem[0] = {MAGIC ^ 32'h0000_0100, 32'(WORDS)};
        else if (r == 1) ctl_mem[0] = {MAGIC, 32'(WORDS + 1)};
        plan_load(); start_op(1, 0);
      end else begin
        for (int i = 0; i < WORDS; i++) core_mem[i] = {$urandom, $urandom};
        plan_save(); start_op(0, 1);
      end
      wait_end(600);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
